// File: rtl/digit_scan_ctrl_if.sv
// Display-side bundle of the digit scan controller: the run request and frame
// data come in, and the decoder selects plus the segment-encoder data go out.
interface digit_scan_ctrl_if;
  logic        run;
  logic [31:0] digits_in;
  logic [7:0]  dp_in;
  logic        sel_a;
  logic        sel_b;
  logic        sel_c;
  logic        sel_en;
  logic [3:0]  digit_bcd;
  logic        digit_dp;
  logic        frame_done;

  modport master (
    output run, digits_in, dp_in,
    input  sel_a, sel_b, sel_c, sel_en, digit_bcd, digit_dp, frame_done
  );

  modport slave (
    input  run, digits_in, dp_in,
    output sel_a, sel_b, sel_c, sel_en, digit_bcd, digit_dp, frame_done
  );
endinterface

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 7-seg scan controller: steps digit slots at CLK_DIV cycles each,
// drives the 3-to-8 decoder selects and shows a per-frame snapshot of the digit data.
module digit_scan_ctrl #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 1000,
  parameter int NUM_DIG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  digit_scan_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W:0]   BLANK_LIM = (CNT_W + 1)'(BLANK_CYC);
  localparam logic [2:0]       SLOT_MAX  = 3'(NUM_DIG - 1);
  localparam logic [3:0]       BLANK_BCD = 4'hF;

  logic [CNT_W-1:0] pre_cnt, pre_cnt_n;
  logic [2:0]       slot, slot_n;
  logic [31:0]      snap_digits, snap_digits_n;
  logic [7:0]       snap_dp, snap_dp_n;
  logic             run_q;
  logic             sel_en_q, sel_en_n;
  logic [3:0]       bcd_q, bcd_n;
  logic             dp_q, dp_n;
  logic             frame_done_q, frame_done_n;

  // Outputs are computed from the next-state values so that, once registered,
  // they line up with the slot and pre_cnt registers of the same cycle.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    pre_cnt_n     = pre_cnt;
    slot_n        = slot;
    snap_digits_n = snap_digits;
    snap_dp_n     = snap_dp;
    frame_done_n  = 1'b0;

    if (!bus.run) begin
      pre_cnt_n = '0;
      slot_n    = '0;
    end else if (!run_q) begin
      // First edge of a run: fresh snapshot, slot 0 gets its full slot time.
      pre_cnt_n     = '0;
      slot_n        = '0;
      snap_digits_n = bus.digits_in;
      snap_dp_n     = bus.dp_in;
    end else if (pre_cnt == CNT_MAX) begin
      pre_cnt_n = '0;
      if (slot == SLOT_MAX) begin
        slot_n        = '0;
        snap_digits_n = bus.digits_in;
        snap_dp_n     = bus.dp_in;
        frame_done_n  = 1'b1;
      end else begin
        slot_n = slot + 3'd1;
      end
    end else begin
      pre_cnt_n = pre_cnt + 1'b1;
    end

    bcd_n = snap_digits_n[{slot_n, 2'b00} +: 4];
    dp_n  = snap_dp_n[slot_n];
    // pre_cnt + 1 > BLANK_CYC is pre_cnt >= BLANK_CYC, written so BLANK_CYC=0 stays clean.
    sel_en_n = bus.run && (({1'b0, pre_cnt_n} + 1'b1) > BLANK_LIM) && (bcd_n != BLANK_BCD);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      pre_cnt      <= '0;
      slot         <= '0;
      snap_digits  <= '0;
      snap_dp      <= '0;
      run_q        <= 1'b0;
      sel_en_q     <= 1'b0;
      bcd_q        <= '0;
      dp_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      pre_cnt      <= pre_cnt_n;
      slot         <= slot_n;
      snap_digits  <= snap_digits_n;
      snap_dp      <= snap_dp_n;
      run_q        <= bus.run;
      sel_en_q     <= sel_en_n;
      bcd_q        <= bcd_n;
      dp_q         <= dp_n;
      frame_done_q <= frame_done_n;
    end
  end

  assign bus.sel_a      = slot[0];
  assign bus.sel_b      = slot[1];
  assign bus.sel_c      = slot[2];
  assign bus.sel_en     = sel_en_q;
  assign bus.digit_bcd  = bcd_q;
  assign bus.digit_dp   = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule
